// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared constants and types for the round-robin arbiter/mux.
//   NUM_REQ  - number of requesters sharing the channel
//   SEL_W    - width of a requester index
//   estado_t - arbiter FSM states (LIBRE: no grant, CONCEDIDO: grant held)
//   a_onehot - index to one-hot grant vector
package arbitro_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        LIBRE,
        CONCEDIDO
    } estado_t;

    function automatic logic [NUM_REQ-1:0] a_onehot(input logic [SEL_W-1:0] sel);
        a_onehot      = '0;
        a_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_prioridad.sv
// rr_prioridad: combinational round-robin search.
//   i_req [3:0] - request vector
//   i_ptr [1:0] - index of the last served requester
//   o_hay       - at least one request found
//   o_idx [1:0] - winner; search order ptr+1, ptr+2, ptr+3, ptr (mod 4)
module rr_prioridad
    import arbitro_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_hay,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk the order backwards so the nearest candidate (ptr+1) is written last
    // and wins; ptr itself (offset NUM_REQ wraps to 0) has lowest priority.
    always_comb begin
        o_hay  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_hay = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_mux.sv
// arbitro_mux: 4-requester round-robin arbiter driving a shared payload mux.
//   i_Clk, i_Rst          - clock, synchronous active-high reset
//   i_Req [3:0]           - requests
//   i_Datos_0..3 [ANCHO]  - payload per requester
//   i_Listo               - downstream ready; transfer = o_Valido & i_Listo
//   o_Gnt [3:0]           - registered one-hot grant (zero when idle)
//   o_Sel [1:0]           - registered index of the granted requester
//   o_Salida [ANCHO]      - payload of the granted requester, zero when invalid
//   o_Valido              - registered: channel holds a granted payload
//   o_Cuenta [CUENTA_W]   - completed transfers, wrapping
module arbitro_mux
    import arbitro_pkg::*;
#(
    parameter int ANCHO    = 4,
    parameter int CUENTA_W = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic [3:0]          i_Req,
    input  logic [ANCHO-1:0]    i_Datos_0,
    input  logic [ANCHO-1:0]    i_Datos_1,
    input  logic [ANCHO-1:0]    i_Datos_2,
    input  logic [ANCHO-1:0]    i_Datos_3,
    input  logic                i_Listo,
    output logic [3:0]          o_Gnt,
    output logic [1:0]          o_Sel,
    output logic [ANCHO-1:0]    o_Salida,
    output logic                o_Valido,
    output logic [CUENTA_W-1:0] o_Cuenta
);

    estado_t             r_estado, w_estado_d;
    logic [SEL_W-1:0]    r_ptr, w_ptr_d;
    logic [SEL_W-1:0]    r_sel, w_sel_d;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_d;
    logic                r_valido, w_valido_d;
    logic [CUENTA_W-1:0] r_cuenta, w_cuenta_d;

    logic                w_transfer;
    logic [SEL_W-1:0]    w_ptr_busq;
    logic                w_hay;
    logic [SEL_W-1:0]    w_idx;
    logic [ANCHO-1:0]    w_mux;

    assign w_transfer = (r_estado == CONCEDIDO) && i_Listo;

    // On a transfer the search starts from the requester just served. The
    // granted bit then comes last in the order, so other requesters win first
    // and it is re-granted only when alone.
    assign w_ptr_busq = w_transfer ? r_sel : r_ptr;

    rr_prioridad u_rr_prioridad (
        .i_req (i_Req),
        .i_ptr (w_ptr_busq),
        .o_hay (w_hay),
        .o_idx (w_idx)
    );

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_estado <= LIBRE;
            r_ptr    <= SEL_W'(NUM_REQ - 1);
            r_sel    <= '0;
            r_gnt    <= '0;
            r_valido <= 1'b0;
            r_cuenta <= '0;
        end else begin
            r_estado <= w_estado_d;
            r_ptr    <= w_ptr_d;
            r_sel    <= w_sel_d;
            r_gnt    <= w_gnt_d;
            r_valido <= w_valido_d;
            r_cuenta <= w_cuenta_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_d = r_estado;
        w_ptr_d    = r_ptr;
        w_cuenta_d = r_cuenta;
        case (r_estado)
            LIBRE: begin
                if (w_hay) w_estado_d = CONCEDIDO;
            end
            CONCEDIDO: begin
                if (w_transfer) begin
                    w_ptr_d    = r_sel;
                    w_cuenta_d = r_cuenta + CUENTA_W'(1);
                    w_estado_d = w_hay ? CONCEDIDO : LIBRE;
                end else if (!i_Req[r_sel]) begin
                    // Requester withdrew before being served
                    w_estado_d = LIBRE;
                end
            end
            default: w_estado_d = LIBRE;
        endcase
    end

    // Output logic: next values of the registered outputs plus the payload mux
    always_comb begin
        w_sel_d    = r_sel;
        w_valido_d = r_valido;
        if (w_estado_d == LIBRE) begin
            w_sel_d    = '0;
            w_valido_d = 1'b0;
        end else if (r_estado == LIBRE || w_transfer) begin
            w_sel_d    = w_idx;
            w_valido_d = 1'b1;
        end
        w_gnt_d = w_valido_d ? a_onehot(w_sel_d) : '0;

        case (r_sel)
            2'd0:    w_mux = i_Datos_0;
            2'd1:    w_mux = i_Datos_1;
            2'd2:    w_mux = i_Datos_2;
            default: w_mux = i_Datos_3;
        endcase
    end

    assign o_Gnt    = r_gnt;
    assign o_Sel    = r_sel;
    assign o_Valido = r_valido;
    assign o_Cuenta = r_cuenta;
    assign o_Salida = r_valido ? w_mux : '0;

endmodule
